inv_checker: RTL

//  - Synthesizable response checker for the inverter: the checking end of the inv stimulus/response pair.
//  - Accepts one stimulus vector a over a valid/ready handshake, waits a settle window, samples the DUT output y, compares it with ~a.
//  - Counts pass/fail, captures the first failure, raises done after NUM_VECTORS checks.
//  - Sits beside inv in on-chip self-test wrappers; the stimulus source drives inv.a and this block in parallel.

---
 rtl/inv_checker_pkg.sv | 21 ++
 rtl/inv_checker_satcnt.sv | 20 ++
 rtl/inv_checker.sv | 122 ++++++++++++
 3 files changed

// File: rtl/inv_checker_pkg.sv
// Shared types and helpers for the inverter response checker.
// The expected-value function is full width so any WIDTH up to INV_MAX_W can use it.
package inv_checker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;
  localparam int INV_MAX_W     = 64;

  function automatic logic [INV_MAX_W-1:0] inv_expected(input logic [INV_MAX_W-1:0] a);
    return ~a;
  endfunction

endpackage

// File: rtl/inv_checker_satcnt.sv
// Saturating up-counter with synchronous clear, used for the pass, fail and vector counts.
module inv_checker_satcnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Holds at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/inv_checker.sv
// Response checker for the inverter: accepts a vector, waits SETTLE_CYCLES, compares y with ~a.
// Build option INV_CHECKER_STOP_ON_FAIL_EN ends the run at the first failing compare.
module inv_checker
  import inv_checker_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_VECTORS   = 2,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_y,
  output logic             busy,
  output logic             done,
  output logic             all_pass
);

  localparam int TIMER_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]   TIMER_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     LAST_VEC   = CNT_W'(NUM_VECTORS - 1);
  localparam logic [INV_MAX_W-1:0] CMP_MASK   = {INV_MAX_W{1'b1}} >> (INV_MAX_W - WIDTH);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [WIDTH-1:0]   a_q;
  logic [CNT_W-1:0]   vec_cnt;
  logic               start_ok, in_check, pass, last_vec;

  assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE));
  assign in_check     = (state_q == CHECK);
  assign pass         = ((INV_MAX_W'(y) ^ inv_expected(INV_MAX_W'(a_q))) & CMP_MASK) == '0;
  assign last_vec     = (vec_cnt >= LAST_VEC);
  assign sample_ready = (state_q == RUN);
  assign busy         = (state_q == RUN) || (state_q == SETTLE) || (state_q == CHECK);
  assign done         = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (sample_valid) state_d = SETTLE;
      SETTLE:     if (timer_q == '0) state_d = CHECK;
      CHECK: begin
`ifdef INV_CHECKER_STOP_ON_FAIL_EN
        if (last_vec || !pass) state_d = DONE;
`else
        if (last_vec) state_d = DONE;
`endif
        else state_d = RUN;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Only the first failing vector of a run is kept; start wipes it for the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q        <= '0;
      a_q            <= '0;
      chk_valid      <= 1'b0;
      chk_pass       <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_a   <= '0;
      first_fail_y   <= '0;
      all_pass       <= 1'b0;
    end else begin
      chk_valid <= in_check;
      chk_pass  <= in_check && pass;
      if (start_ok) begin
        first_fail_vld <= 1'b0;
        first_fail_a   <= '0;
        first_fail_y   <= '0;
        all_pass       <= 1'b0;
      end
      if ((state_q == RUN) && sample_valid) begin
        a_q     <= a;
        timer_q <= TIMER_LOAD;
      end else if (state_q == SETTLE) begin
        timer_q <= timer_q - TIMER_W'(1);
      end
      if (in_check && !pass && !first_fail_vld) begin
        first_fail_vld <= 1'b1;
        first_fail_a   <= a_q;
        first_fail_y   <= y;
      end
      if (in_check && (state_d == DONE))
        all_pass <= pass && (fail_cnt == '0);
    end
  end

  inv_checker_satcnt #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk(clk), .rst(rst), .clr(start_ok), .inc(in_check && pass),  .cnt(pass_cnt)
  );

  inv_checker_satcnt #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk(clk), .rst(rst), .clr(start_ok), .inc(in_check && !pass), .cnt(fail_cnt)
  );

  inv_checker_satcnt #(.CNT_W(CNT_W)) u_vec_cnt (
    .clk(clk), .rst(rst), .clr(start_ok), .inc(in_check),          .cnt(vec_cnt)
  );

endmodule
